cluster_dispatch_ctrl: RTL and testbench
========================================

CLUSTER_DISPATCH_CTRL -- requirements
Module: cluster_dispatch_ctrl

Interface
REQ-001 Parameter NUM_PE, default 4, number of PE lanes (1..8).
REQ-002 Parameter XLEN, default 32, instruction and PC width.
REQ-003 Parameter RESET_PC, default 0, base PC loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 run  input  1  level; allows leaving IDLE and starting the next fetch.
REQ-007 instruction_mem  input  NUM_PE*XLEN  fetched instructions, lane i in bits [i*XLEN +: XLEN], valid one cycle after InstReadEn.
REQ-008 PCsIM  output  NUM_PE*XLEN  per-lane fetch PCs to instruction memory.
REQ-009 InstReadEn  output  NUM_PE  per-lane instruction memory read enables.
REQ-010 PCinPE  output  NUM_PE*XLEN  per-lane PC presented to each PE.
REQ-011 instruction_outPE  output  NUM_PE*XLEN  per-lane instruction presented to each PE.
REQ-012 issue_valid  output  NUM_PE  one-cycle pulse per lane; PE i starts when bit i is 1.
REQ-013 PCoutPE  input  NUM_PE*XLEN  next PC reported by each PE, sampled with its completion pulse.
REQ-014 execution_complete  input  NUM_PE  per-lane completion pulse.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, FETCH, WAIT_MEM, CHECK, ISSUE, EXEC, with the transitions below.
- IDLE -> FETCH when run = 1.
- FETCH -> WAIT_MEM.
- WAIT_MEM -> CHECK.
- CHECK -> ISSUE.
- ISSUE -> EXEC.
- EXEC -> ISSUE when the wave is done and pending is nonzero.
- EXEC -> FETCH when the wave is done, pending is zero and run = 1.
- EXEC -> IDLE when the wave is done, pending is zero and run = 0.
REQ-017 FETCH: InstReadEn = all ones for exactly one cycle; PCsIM lane i = pc_reg[i]. InstReadEn = 0 in all other states.
REQ-018 WAIT_MEM: the bundle register captures instruction_mem on the clock edge that leaves WAIT_MEM; pending = all ones.
REQ-019 Field decode per lane: opcode[6:0], rd[11:7], rs1[19:15], rs2[24:20].
REQ-020 writes_rd is true when rd != 0 and opcode is one of 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
REQ-021 uses_rs1 is true for all opcodes except 0110111, 0010111 and 1101111; uses_rs2 is true for opcodes 0110011, 0100011 and 1100011.
REQ-022 dep(i,j), for i < j, is true when writes_rd(i) and at least one of the following holds:
- RAW: uses_rs1(j) and rs1(j) == rd(i).
- RAW: uses_rs2(j) and rs2(j) == rd(i).
- WAW: writes_rd(j) and rd(j) == rd(i).
REQ-023 CHECK registers the full dep matrix; the matrix is fixed for the rest of the bundle.
REQ-024 ISSUE: lane j is issued if pending[j] = 1 and no i < j has pending[i] = 1 with dep(i,j) = 1. The lowest pending lane therefore always issues, so forward progress is guaranteed.
REQ-025 ISSUE: issue_valid = issued mask for exactly one cycle. The wave register latches the mask.
REQ-026 PCinPE and instruction_outPE are loaded for issued lanes in ISSUE and held until the next ISSUE or reset.
REQ-027 EXEC: execution_complete[i] sets sticky done[i] only if wave[i] = 1; pulses on other lanes are ignored. On the same edge, PCoutPE lane i is captured into next_pc[i].
REQ-028 Wave done is (done & wave) == wave.
- On the wave-done cycle, pending clears the wave bits, and done and wave clear.
- A pulse in the same cycle that completes the wave counts toward it.
REQ-029 Pulses arriving in any state other than EXEC are ignored.
REQ-030 On EXEC -> FETCH or EXEC -> IDLE, pc_reg[i] takes next_pc[i] for every lane.
REQ-031 No timeout: EXEC waits indefinitely for completion pulses.

Reset
REQ-032 While reset = 1, the following SHALL hold:
- State = IDLE.
- pc_reg[i] = RESET_PC + 4*i.
- next_pc, bundle, pending, wave and done = 0.
- All outputs = 0.
REQ-033 Reset asserted in any state, including mid-EXEC, SHALL abandon the bundle in the next cycle; completions arriving after reset are ignored.

Verification
REQ-034 Reset held, then run = 1: one cycle after reset deasserts, FETCH with InstReadEn = 1111 and PCsIM = {0x0C, 0x08, 0x04, 0x00}; busy = 1.
REQ-035 Independent bundle (add x3,x0,x1; add x5,x2,x4; add x8,x6,x7; add x11,x9,x10): single wave, issue_valid = 1111 for one cycle; all four completions, then FETCH.
REQ-036 RAW chain (lane0 add x5,x1,x2; lane1 add x6,x5,x3; lane2 add x7,x1,x2; lane3 add x8,x6,x7): waves are issue_valid = 0101, then 0010, then 1000.
REQ-037 WAW and x0: lane0 writes x9, lane2 writes x9, lane1 writes x0 and lane3 reads x0 -> wave1 issue_valid = 1011, wave2 issue_valid = 0100.
REQ-038 Completions out of order (lane 2 before 0), plus a spurious pulse on non-issued lane 3 during wave1 of REQ-036 -> wave2 issues only after lanes 0 and 2 complete; the lane-3 pulse is ignored; next FETCH PCsIM equals the PCoutPE values sampled.
REQ-039 Reset asserted mid-EXEC, then released with run = 1: the next FETCH uses the reset PCs, and completion pulses received during reset have no effect.

Source files
------------

// File: rtl/cluster_dispatch_ctrl.sv
// Cluster dispatch controller: fetches one instruction per PE lane, then
// issues hazard-free waves of that bundle until every lane has executed.
module cluster_dispatch_ctrl #(
  parameter int NUM_PE = 4,
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_PE*XLEN-1:0] instruction_mem,
  output logic [NUM_PE*XLEN-1:0] PCsIM,
  output logic [NUM_PE-1:0]      InstReadEn,
  output logic [NUM_PE*XLEN-1:0] PCinPE,
  output logic [NUM_PE*XLEN-1:0] instruction_outPE,
  output logic [NUM_PE-1:0]      issue_valid,
  input  logic [NUM_PE*XLEN-1:0] PCoutPE,
  input  logic [NUM_PE-1:0]      execution_complete,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_MEM, CHECK, ISSUE, EXEC
  } state_e;

  typedef logic [NUM_PE-1:0][XLEN-1:0] lanes_t;
  typedef logic [NUM_PE-1:0][NUM_PE-1:0] mat_t;

  state_e state_q, state_d;
  lanes_t pc_q, pc_d;
  lanes_t npc_q, npc_d;
  lanes_t bund_q, bund_d;
  lanes_t pcpe_q, pcpe_d;
  lanes_t inst_q, inst_d;
  logic [NUM_PE-1:0] pend_q, pend_d;
  logic [NUM_PE-1:0] wave_q, wave_d;
  logic [NUM_PE-1:0] done_q, done_d;
  mat_t dep_q, dep_d, dep_c;
  logic [NUM_PE-1:0] wr_c, u1_c, u2_c;
  logic [NUM_PE-1:0] issue_c;
  logic [NUM_PE-1:0] acc_c, dnew_c;

  function automatic logic f_wr(
    input logic [6:0] op,
    input logic [4:0] rd
  );
    logic hit;
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011,
      7'b0110111, 7'b0010111, 7'b1101111,
      7'b1100111: hit = 1'b1;
      default:    hit = 1'b0;
    endcase
    return hit && (rd != 5'd0);
  endfunction

  function automatic logic f_u1(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111,
      7'b1101111: return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic f_u2(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0100011,
      7'b1100011: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  always_comb begin
    wr_c  = '0;
    u1_c  = '0;
    u2_c  = '0;
    dep_c = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      wr_c[i] = f_wr(bund_q[i][6:0], bund_q[i][11:7]);
      u1_c[i] = f_u1(bund_q[i][6:0]);
      u2_c[i] = f_u2(bund_q[i][6:0]);
    end
    for (int i = 0; i < NUM_PE; i++) begin
      for (int j = 0; j < NUM_PE; j++) begin
        if (i < j) begin
          dep_c[i][j] = wr_c[i] && (
            (u1_c[j] && bund_q[j][19:15] == bund_q[i][11:7]) ||
            (u2_c[j] && bund_q[j][24:20] == bund_q[i][11:7]) ||
            (wr_c[j] && bund_q[j][11:7]  == bund_q[i][11:7]));
        end
      end
    end
  end

  // A lane is blocked only by an older lane that is still pending.
  always_comb begin
    logic blk;
    issue_c = '0;
    blk     = 1'b0;
    for (int j = 0; j < NUM_PE; j++) begin
      blk = 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
        if (i < j) blk = blk | (pend_q[i] & dep_q[i][j]);
      end
      issue_c[j] = pend_q[j] & ~blk;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    bund_d  = bund_q;
    pcpe_d  = pcpe_q;
    inst_d  = inst_q;
    pend_d  = pend_q;
    wave_d  = wave_q;
    done_d  = done_q;
    dep_d   = dep_q;
    acc_c   = execution_complete & wave_q;
    dnew_c  = done_q | acc_c;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: state_d = WAIT_MEM;
      WAIT_MEM: begin
        bund_d  = lanes_t'(instruction_mem);
        pend_d  = '1;
        state_d = CHECK;
      end
      CHECK: begin
        dep_d   = dep_c;
        state_d = ISSUE;
      end
      ISSUE: begin
        wave_d = issue_c;
        for (int i = 0; i < NUM_PE; i++) begin
          if (issue_c[i]) begin
            pcpe_d[i] = pc_q[i];
            inst_d[i] = bund_q[i];
          end
        end
        state_d = EXEC;
      end
      EXEC: begin
        for (int i = 0; i < NUM_PE; i++) begin
          if (acc_c[i]) npc_d[i] = PCoutPE[i*XLEN +: XLEN];
        end
        if ((dnew_c & wave_q) == wave_q) begin
          pend_d = pend_q & ~wave_q;
          done_d = '0;
          wave_d = '0;
          if (pend_d != '0) begin
            state_d = ISSUE;
          end else begin
            pc_d    = npc_d;
            state_d = run ? FETCH : IDLE;
          end
        end else begin
          done_d = dnew_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_PE; i++) begin
        pc_q[i] <= RESET_PC + XLEN'(4 * i);
      end
      npc_q  <= '0;
      bund_q <= '0;
      pcpe_q <= '0;
      inst_q <= '0;
      pend_q <= '0;
      wave_q <= '0;
      done_q <= '0;
      dep_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      bund_q  <= bund_d;
      pcpe_q  <= pcpe_d;
      inst_q  <= inst_d;
      pend_q  <= pend_d;
      wave_q  <= wave_d;
      done_q  <= done_d;
      dep_q   <= dep_d;
    end
  end

  assign InstReadEn = (!reset && state_q == FETCH) ? '1 : '0;
  assign PCsIM = (!reset && state_q == FETCH) ? pc_q : '0;
  assign issue_valid = (!reset && state_q == ISSUE) ? issue_c : '0;
  assign busy = !reset && (state_q != IDLE);
  assign PCinPE = pcpe_q;
  assign instruction_outPE = inst_q;

endmodule

// File: tb/tb_cluster_dispatch_ctrl.sv
// Randomised bench for cluster_dispatch_ctrl against a wave-level model
// of bundle dispatch (waves, fetch PCs, PE-side registers).
module tb_cluster_dispatch_ctrl;
  localparam int NUM_PE = 4;
  localparam int XLEN = 32;
  localparam int W = NUM_PE * XLEN;
  localparam logic [XLEN-1:0] RPC = 32'h0;
  localparam logic [6:0] OPS [10] = '{
    7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111,
    7'b1101111, 7'b1100111, 7'b0100011, 7'b1100011, 7'b0001111};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic [W-1:0] instruction_mem = '0;
  logic [W-1:0] PCsIM, PCinPE, instruction_outPE;
  logic [W-1:0] PCoutPE = '0;
  logic [NUM_PE-1:0] InstReadEn, issue_valid;
  logic [NUM_PE-1:0] execution_complete = '0;
  logic busy;

  always #5 clk = ~clk;

  cluster_dispatch_ctrl #(.NUM_PE(NUM_PE), .XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .run(run),
    .instruction_mem(instruction_mem), .PCsIM(PCsIM),
    .InstReadEn(InstReadEn), .PCinPE(PCinPE),
    .instruction_outPE(instruction_outPE), .issue_valid(issue_valid),
    .PCoutPE(PCoutPE), .execution_complete(execution_complete),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NUM_PE-1:0][XLEN-1:0] exp_pc, exp_next, e_pcpe, e_inst;
  logic [NUM_PE-1:0] exp_waves[$];
  logic [NUM_PE-1:0] mw[$];
  logic [W-1:0] mem_bundle = '0;

  function automatic bit m_wr(input logic [31:0] x);
    return x[11:7] != 5'd0 && (x[6:0] inside {7'b0110011, 7'b0010011,
      7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111});
  endfunction
  function automatic bit m_u1(input logic [31:0] x);
    return !(x[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
  endfunction
  function automatic bit m_u2(input logic [31:0] x);
    return x[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit m_dep(input logic [31:0] a, input logic [31:0] b);
    return m_wr(a) && ((m_u1(b) && b[19:15] == a[11:7]) ||
                       (m_u2(b) && b[24:20] == a[11:7]) ||
                       (m_wr(b) && b[11:7] == a[11:7]));
  endfunction

  // Peel off, round by round, every pending lane with no pending older producer.
  task automatic m_waves(input logic [W-1:0] b);
    logic [NUM_PE-1:0] pend, m;
    bit blk;
    mw.delete();
    pend = '1;
    while (pend != '0) begin
      m = '0;
      for (int j = 0; j < NUM_PE; j++) begin
        if (pend[j]) begin
          blk = 1'b0;
          for (int i = 0; i < j; i++)
            if (pend[i] && m_dep(b[i*XLEN +: XLEN], b[j*XLEN +: XLEN]))
              blk = 1'b1;
          if (!blk) m[j] = 1'b1;
        end
      end
      mw.push_back(m);
      pend &= ~m;
    end
  endtask

  function automatic logic [31:0] packw();
    logic [31:0] r = '0;
    foreach (mw[k]) r = (r << NUM_PE) | 32'(mw[k]);
    return r;
  endfunction

  function automatic logic [31:0] r_add(input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int i = 0; i < NUM_PE; i++) r[i*XLEN +: XLEN] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_bundle();
    logic [W-1:0] r;
    logic [31:0] x;
    for (int i = 0; i < NUM_PE; i++) begin
      x = $urandom;
      x[6:0] = OPS[$urandom_range(0, 9)];
      x[11:7] = 5'($urandom_range(0, 7));
      x[19:15] = 5'($urandom_range(0, 7));
      x[24:20] = 5'($urandom_range(0, 7));
      r[i*XLEN +: XLEN] = x;
    end
    return r;
  endfunction

  task automatic set_base();
    for (int i = 0; i < NUM_PE; i++) begin
      exp_pc[i] = RPC + 32'(4 * i);
      exp_next[i] = RPC + 32'(4 * i);
    end
  endtask

  // Instruction memory answers exactly one cycle after a read; garbage otherwise.
  bit mem_rd;
  always @(posedge clk) begin
    mem_rd = |InstReadEn;
    #1 instruction_mem = mem_rd ? mem_bundle : rnd_w();
  end

  // ---------------- compare process ----------------
  bit rst_edge = 1'b0;
  logic [NUM_PE-1:0] outst = '0;
  always @(posedge clk) rst_edge = reset;

  initial begin
    e_pcpe = '0;
    e_inst = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (rst_edge) begin
          chk("reset_ctl", W'({InstReadEn, issue_valid, busy}), '0);
          chk("reset_pcs", PCsIM | PCinPE | instruction_outPE, '0);
        end
        exp_waves.delete();
        outst = '0;
        e_pcpe = '0;
        e_inst = '0;
      end else begin
        chk("pc_in_pe", PCinPE, W'(e_pcpe));
        chk("inst_out_pe", instruction_outPE, W'(e_inst));
        if (InstReadEn != '0) begin
          chk("fetch_rden", W'(InstReadEn), W'({NUM_PE{1'b1}}));
          chk("fetch_pc", PCsIM, W'(exp_pc));
          chk("fetch_busy", W'(busy), W'(1'b1));
        end
        if (issue_valid != '0) begin
          chk("early_issue", W'(outst), '0);
          chk("issue_busy", W'(busy), W'(1'b1));
          if (exp_waves.size() == 0) chk("extra_wave", W'(issue_valid), '0);
          else chk("wave", W'(issue_valid), W'(exp_waves.pop_front()));
          outst = issue_valid;
          for (int i = 0; i < NUM_PE; i++) begin
            if (issue_valid[i]) begin
              e_pcpe[i] = exp_pc[i];
              e_inst[i] = mem_bundle[i*XLEN +: XLEN];
            end
          end
        end
        outst &= ~execution_complete;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: random delays; 1: plus random spurious pulse; 2: lane 2 before 0 and lane-3 spur
  task automatic do_bundle(input logic [W-1:0] b, input int mode, input bit last);
    int n, t, maxd;
    int d[NUM_PE];
    logic [NUM_PE-1:0] mask;
    logic [XLEN-1:0] v;
    mem_bundle = b;
    m_waves(b);
    foreach (mw[k]) exp_waves.push_back(mw[k]);
    n = mw.size();
    for (int w = 0; w < n; w++) begin
      t = 0;
      while (issue_valid == '0 && t < 40) begin
        step();
        t++;
      end
      if (issue_valid == '0) begin
        chk("issue_timeout", W'(issue_valid), W'(mw[w]));
        return;
      end
      mask = issue_valid;
      if (last && w == 0) run = 1'b0;
      maxd = 0;
      for (int i = 0; i < NUM_PE; i++) begin
        d[i] = 0;
        if (mask[i]) begin
          if (mode == 2 && w == 0) d[i] = (i == 0) ? 3 : 1;
          else d[i] = int'($urandom_range(1, 4));
          if (d[i] > maxd) maxd = d[i];
        end
      end
      for (int k = 1; k <= maxd; k++) begin
        step();
        PCoutPE = rnd_w();
        execution_complete = '0;
        for (int i = 0; i < NUM_PE; i++) begin
          if (mask[i] && d[i] == k) begin
            v = $urandom & 32'hFFFF_FFFC;
            PCoutPE[i*XLEN +: XLEN] = v;
            exp_next[i] = v;
            execution_complete[i] = 1'b1;
          end
        end
        if (k == 1 && ((mode == 2 && w == 0) ||
                       (mode == 1 && $urandom_range(0, 1) == 1))) begin
          for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (!mask[i] && !execution_complete[NUM_PE-1]) begin
              if (i == NUM_PE - 1 || mask[NUM_PE-1]) begin
                execution_complete[i] = 1'b1;
                PCoutPE[i*XLEN +: XLEN] = 32'hDEAD_BEE0;
              end
            end
          end
        end
      end
      step();
      execution_complete = '0;
    end
    exp_pc = exp_next;
    if (last) begin
      repeat (3) begin
        step();
        chk("idle_busy", W'(busy), W'(1'b0));
        chk("idle_rden", W'(InstReadEn), '0);
      end
      run = 1'b1;
    end
  endtask

  task automatic rst_mid(input logic [W-1:0] b);
    int t;
    mem_bundle = b;
    m_waves(b);
    foreach (mw[k]) exp_waves.push_back(mw[k]);
    t = 0;
    while (issue_valid == '0 && t < 40) begin
      step();
      t++;
    end
    chk("rstmid_issue", W'(issue_valid), W'(mw[0]));
    step();
    reset = 1'b1;
    execution_complete = '1;
    PCoutPE = rnd_w();
    repeat (3) step();
    reset = 1'b0;
    execution_complete = '0;
    set_base();
  endtask

  logic [W-1:0] b35, b36, b37;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_base();
    b35 = {r_add(11, 9, 10), r_add(8, 6, 7), r_add(5, 2, 4), r_add(3, 0, 1)};
    b36 = {r_add(8, 6, 7), r_add(7, 1, 2), r_add(6, 5, 3), r_add(5, 1, 2)};
    b37 = {r_add(10, 0, 7), r_add(9, 5, 6), r_add(0, 3, 4), r_add(9, 1, 2)};
    m_waves(b35);
    chk("pin_indep", W'(packw()), W'(32'hF));
    m_waves(b36);
    chk("pin_raw", W'(packw()), W'(32'h528));
    m_waves(b37);
    chk("pin_waw_x0", W'(packw()), W'(32'hB4));

    reset = 1'b1;
    run = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    mem_bundle = b35;
    step();
    chk("first_fetch_pc", PCsIM, {32'hC, 32'h8, 32'h4, 32'h0});
    chk("first_fetch_rden", W'(InstReadEn), W'(4'b1111));
    chk("first_fetch_busy", W'(busy), W'(1'b1));
    do_bundle(b35, 0, 1'b0);
    do_bundle(b36, 0, 1'b0);
    do_bundle(b37, 0, 1'b0);
    do_bundle(b36, 2, 1'b0);
    rst_mid(b36);
    do_bundle(b35, 1, 1'b0);
    for (int n = 0; n < 24; n++)
      do_bundle(rnd_bundle(), int'($urandom_range(0, 1)), n % 6 == 5);
    do_bundle(rnd_bundle(), 1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
